shift_sequencer: RTL

//  Control stage directly upstream of the n-bit load/shift/rotate register.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_sequencer_cmd_hold_reg.sv | 47 ++++
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its holding register.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_SHIFT = 1'b0;
  localparam logic DIR_ROT   = 1'b1;

  // Default configuration, matching the 8-bit downstream register.
  localparam int DEF_N          = 8;
  localparam int DEF_MAX_SHIFTS = 8;
  localparam int DEF_CW         = $clog2(DEF_MAX_SHIFTS + 1);

  // One command as offered on the cmd_* port (default widths).
  typedef struct packed {
    logic [DEF_N-1:0]  data;
    logic              dir;
    logic [DEF_CW-1:0] count;
  } cmd_t;

endpackage

// File: rtl/shift_sequencer_cmd_hold_reg.sv
// One-entry command holding register. Empty -> ready. A pop frees the entry,
// but ready only rises the cycle after the pop (no same-cycle bypass).
// Step counts above MAX_SHIFTS are clamped on capture.
module cmd_hold_reg #(
  parameter int N          = 8,
  parameter int MAX_SHIFTS = 8,
  parameter int CW         = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [CW-1:0] in_count,
  input  logic          pop,
  output logic          pend_valid,
  output logic [N-1:0]  pend_data,
  output logic          pend_dir,
  output logic [CW-1:0] pend_count
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_SHIFTS);

  logic [CW-1:0] count_sat;

  assign in_ready  = !pend_valid;
  assign count_sat = (in_count > MAX_C) ? MAX_C : in_count;

  // Capture a command when empty and offered; release it on pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_dir   <= 1'b0;
      pend_count <= '0;
    end else if (pop) begin
      pend_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      pend_valid <= 1'b1;
      pend_data  <= in_data;
      pend_dir   <= in_dir;
      pend_count <= count_sat;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Control stage for an N-bit load/shift/rotate register: one parallel load
// followed by a counted run of shift (serial fill) or rotate steps.
// All sr_*, busy and done outputs come straight from flops; only cmd_ready and
// ser_ready are decoded, and only from registered state.
//
// Handshakes: a transfer happens at a rising clock edge where valid and ready
// are both 1. valid must not depend on ready; ready never depends on valid.
// On cmd_*, ready means the holding register is empty. On ser_*, ready is
// high only while a shift-mode command still has steps outstanding.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter  int N          = DEF_N,
  parameter  int MAX_SHIFTS = DEF_MAX_SHIFTS,
  localparam int CW         = $clog2(MAX_SHIFTS + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_count,
  input  logic          ser_valid,
  output logic          ser_ready,
  input  logic          ser_bit,
  output logic          sr_load,
  output logic [N-1:0]  sr_d,
  output logic          sr_en,
  output logic          sr_rl,
  output logic          sr_serial,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  state_t        state, next_state;
  logic [CW-1:0] remaining, remaining_d;
  logic          pop;
  logic          ser_hs;
  logic          load_d, en_d, serial_d, busy_d, done_d;

  logic          pend_valid;
  logic [N-1:0]  pend_data;
  logic          pend_dir;
  logic [CW-1:0] pend_count;

  cmd_hold_reg #(
    .N          (N),
    .MAX_SHIFTS (MAX_SHIFTS),
    .CW         (CW)
  ) u_hold (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (cmd_valid),
    .in_ready   (cmd_ready),
    .in_data    (cmd_data),
    .in_dir     (cmd_dir),
    .in_count   (cmd_count),
    .pop        (pop),
    .pend_valid (pend_valid),
    .pend_data  (pend_data),
    .pend_dir   (pend_dir),
    .pend_count (pend_count)
  );

  // sr_rl doubles as the working direction of the active command.
  assign ser_ready = (state == SHIFT) && (sr_rl == DIR_SHIFT) && (remaining != '0);
  assign ser_hs    = ser_valid && ser_ready;
  assign dbg_state = state;

  // Next state, step counter and the values the output flops take next cycle.
  always_comb begin
    next_state  = state;
    remaining_d = remaining;
    pop         = 1'b0;
    serial_d    = sr_serial;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = (remaining == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (sr_rl == DIR_ROT) begin
          // One step per cycle; the step that brings remaining to 0 is the
          // current cycle's pulse, so leave immediately afterwards.
          remaining_d = remaining - CW'(1);
          if (remaining == CW'(1)) next_state = DONE;
        end else if (remaining == '0) begin
          // Last accepted fill bit is being applied this cycle.
          next_state = DONE;
        end else if (ser_hs) begin
          remaining_d = remaining - CW'(1);
          serial_d    = ser_bit;
        end
      end
      DONE: begin
        if (pend_valid) begin
          pop        = 1'b1;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (pop) remaining_d = pend_count;
    load_d = (next_state == LOAD);
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
    // Rotate pulses on every SHIFT cycle; shift pulses the cycle after a fill bit is taken.
    en_d   = (sr_rl == DIR_ROT) ? (next_state == SHIFT) : ser_hs;
  end

  // State, counter and registered register-control outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      sr_load   <= 1'b0;
      sr_d      <= '0;
      sr_en     <= 1'b0;
      sr_rl     <= 1'b0;
      sr_serial <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      remaining <= remaining_d;
      sr_load   <= load_d;
      sr_en     <= en_d;
      sr_serial <= serial_d;
      busy      <= busy_d;
      done      <= done_d;
      if (pop) begin
        sr_d  <= pend_data;
        sr_rl <= pend_dir;
      end
    end
  end

endmodule
